reg_bank4_4bit: RTL and testbench

Four-entry, 4-bit register bank with a built-in select scanner; sits directly upstream of the 4-bit 4:1 mux stage (`mux4_4bit`). It drives the mux data inputs `in0`..`in3` from its registers and its select `s` from a small scan FSM. The mux output is valid for the same cycles that `sel_valid` is high. It replaces the free-running random stimulus with deterministic, CPU-style operand storage and sequencing.

---
 rtl/reg_bank4_4bit_pkg.sv | 16 +
 rtl/reg_bank4_4bit_if.sv | 36 +++
 rtl/reg_bank4_4bit_reg4_en.sv | 26 ++
 rtl/reg_bank4_4bit.sv | 115 +++++++++++
 tb/tb_reg_bank4_4bit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/reg_bank4_4bit_pkg.sv
// reg_bank_pkg: shared constants and types for the reg_bank4_4bit slice.
//   N_REGS       - number of registers in the bank
//   ADDR_W       - width of a register index / mux select
//   scan_state_t - select-scanner FSM states
package reg_bank_pkg;

  localparam int unsigned N_REGS = 4;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/reg_bank4_4bit_if.sv
// reg_bank4_4bit_if: bus between a register-bank client (master) and the
// register bank (slave).
//   Client -> bank : wr_en, wr_addr, wr_data, scan_start, scan_hold
//   Bank -> client : q0..q3 (mux data), s (mux select), sel_valid,
//                    scan_busy, scan_done
interface reg_bank4_4bit_if #(
  parameter int DATA_W = 4
);
  import reg_bank_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              scan_start;
  logic              scan_hold;

  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [DATA_W-1:0] q2;
  logic [DATA_W-1:0] q3;
  logic [ADDR_W-1:0] s;
  logic              sel_valid;
  logic              scan_busy;
  logic              scan_done;

  modport master (
    output wr_en, wr_addr, wr_data, scan_start, scan_hold,
    input  q0, q1, q2, q3, s, sel_valid, scan_busy, scan_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, scan_start, scan_hold,
    output q0, q1, q2, q3, s, sel_valid, scan_busy, scan_done
  );

endinterface

// File: rtl/reg_bank4_4bit_reg4_en.sv
// reg4_en: one DATA_W-bit register with load enable.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads RESET_VAL
//   en    - load enable
//   d     - load data
//   q     - register contents
module reg4_en #(
  parameter int              DATA_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank4_4bit.sv
// reg_bank4_4bit: four-entry register bank with a one-shot select scanner,
// feeding the data inputs and select of a downstream 4:1 mux.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of reg_bank4_4bit_if:
//           wr_en/wr_addr/wr_data write one register per cycle;
//           scan_start launches a 4-step scan of s (0..3) from IDLE only;
//           scan_hold freezes the scan; q0..q3 register contents;
//           sel_valid marks active scan steps; scan_busy covers SCAN and
//           DONE; scan_done pulses once after the last step.
// Optional feature macro: REG_BANK_BYPASS_EN - a write shows on its q output
// combinationally in the same cycle (write-through). Default build: q comes
// only from the registers.
module reg_bank4_4bit #(
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = 4'h0
) (
  input logic              clk,
  input logic              rst_n,
  reg_bank4_4bit_if.slave  bus
);
  import reg_bank_pkg::*;

  logic [DATA_W-1:0] reg_q  [N_REGS];
  logic [DATA_W-1:0] q_view [N_REGS];

  scan_state_t       state;
  logic [ADDR_W-1:0] s_q;
  logic              sel_valid_q;
  logic              scan_busy_q;
  logic              scan_done_q;

  // Register storage: one-hot enables decoded from the write strobe.
  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_regs
    reg4_en #(
      .DATA_W   (DATA_W),
      .RESET_VAL(RESET_VAL)
    ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (bus.wr_en && (bus.wr_addr == ADDR_W'(gi))),
      .d    (bus.wr_data),
      .q    (reg_q[gi])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REGS; i++) begin
      q_view[i] = reg_q[i];
`ifdef REG_BANK_BYPASS_EN
      // Write-through only when the write will actually land, so reset
      // still forces every output to RESET_VAL.
      if (rst_n && bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
        q_view[i] = bus.wr_data;
      end
`endif
    end
  end

  // Scan FSM with registered outputs. s is left at 3 after a scan and only
  // reloads to 0 on the next accepted scan_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_q         <= '0;
      sel_valid_q <= 1'b0;
      scan_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          scan_done_q <= 1'b0;
          if (bus.scan_start) begin
            state       <= SCAN;
            s_q         <= '0;
            sel_valid_q <= 1'b1;
            scan_busy_q <= 1'b1;
          end
        end
        SCAN: begin
          if (!bus.scan_hold) begin
            if (s_q == ADDR_W'(N_REGS - 1)) begin
              state       <= DONE;
              sel_valid_q <= 1'b0;
              scan_done_q <= 1'b1;
            end else begin
              s_q <= s_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          scan_done_q <= 1'b0;
          scan_busy_q <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          sel_valid_q <= 1'b0;
          scan_busy_q <= 1'b0;
          scan_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q0        = q_view[0];
  assign bus.q1        = q_view[1];
  assign bus.q2        = q_view[2];
  assign bus.q3        = q_view[3];
  assign bus.s         = s_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.scan_busy = scan_busy_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_reg_bank4_4bit.sv
// tb_reg_bank4_4bit: directed, table-driven bench for reg_bank4_4bit with a
// model of the downstream 4:1 mux (out = q[s]).
module tb_reg_bank4_4bit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_bank4_4bit_if #(.DATA_W(4)) bus ();

  reg_bank4_4bit #(
    .DATA_W   (4),
    .RESET_VAL(4'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       hold;
    logic [1:0] e_s;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_mux;
    logic [15:0] e_q;
  } vec_t;

  vec_t vecs [26];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [3:0] mux_out();
    case (bus.s)
      2'd0:    return bus.q0;
      2'd1:    return bus.q1;
      2'd2:    return bus.q2;
      default: return bus.q3;
    endcase
  endfunction

  function automatic logic [15:0] q_all();
    return {bus.q3, bus.q2, bus.q1, bus.q0};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                       input logic st, input logic hd);
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.scan_start = st;
    bus.scan_hold  = hd;
  endtask

  initial begin
    // Phase 1: load 3,5,A,C. Phase 2: plain scan. Phase 3: held scan.
    // Phase 4: scan_start ignored in SCAN (s=1, s=2) and in DONE.
    vecs[0]  = '{1'b1, 2'd0, 4'h3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0003};
    vecs[1]  = '{1'b1, 2'd1, 4'h5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0053};
    vecs[2]  = '{1'b1, 2'd2, 4'hA, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0A53};
    vecs[3]  = '{1'b1, 2'd3, 4'hC, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'hCA53};
    vecs[4]  = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h3, 16'hCA53};
    vecs[5]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4'h5, 16'hCA53};
    vecs[6]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'hA, 16'hCA53};
    vecs[7]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'hC, 16'hCA53};
    vecs[8]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 4'h0, 16'hCA53};
    vecs[9]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 16'hCA53};
    vecs[10] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h3, 16'hCA53};
    vecs[11] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4'h5, 16'hCA53};
    vecs[12] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'h5, 16'hCA53};
    vecs[13] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'h5, 16'hCA53};
    vecs[14] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'h5, 16'hCA53};
    vecs[15] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'hA, 16'hCA53};
    vecs[16] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'hC, 16'hCA53};
    vecs[17] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 4'h0, 16'hCA53};
    vecs[18] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 16'hCA53};
    vecs[19] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h3, 16'hCA53};
    vecs[20] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4'h5, 16'hCA53};
    vecs[21] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'hA, 16'hCA53};
    vecs[22] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'hC, 16'hCA53};
    vecs[23] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 4'h0, 16'hCA53};
    vecs[24] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 16'hCA53};
    vecs[25] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 16'hCA53};

    // Reset with a write to address 2 pending: the write must not land.
    rst_n = 1'b0;
    drive(1'b1, 2'd2, 4'hF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q",         q_all(),                 16'h0000);
    chk("reset_s",         {14'd0, bus.s},          16'd0);
    chk("reset_sel_valid", {15'd0, bus.sel_valid},  16'd0);
    chk("reset_busy",      {15'd0, bus.scan_busy},  16'd0);
    chk("reset_done",      {15'd0, bus.scan_done},  16'd0);
    @(negedge clk);
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].start, vecs[i].hold);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_s", i),     {14'd0, bus.s},         {14'd0, vecs[i].e_s});
      chk($sformatf("v%0d_valid", i), {15'd0, bus.sel_valid}, {15'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_busy", i),  {15'd0, bus.scan_busy}, {15'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_done", i),  {15'd0, bus.scan_done}, {15'd0, vecs[i].e_done});
      chk($sformatf("v%0d_q", i),     q_all(),                vecs[i].e_q);
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_mux", i), {12'd0, mux_out()},     {12'd0, vecs[i].e_mux});
    end

    // Same-cycle write of 9 to register 2 while s=2.
    @(negedge clk);
    drive(1'b0, 2'd0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("wt_pre_s", {14'd0, bus.s}, 16'd2);
    drive(1'b1, 2'd2, 4'h9, 1'b0, 1'b0);
    #1;
`ifdef REG_BANK_BYPASS_EN
    chk("wt_same_cycle_mux", {12'd0, mux_out()}, 16'h0009);
`else
    chk("wt_same_cycle_mux", {12'd0, mux_out()}, 16'h000A);
`endif
    @(posedge clk);
    #1;
    chk("wt_next_q2", {12'd0, bus.q2}, 16'h0009);
    chk("wt_next_s",  {14'd0, bus.s},  16'd3);
    @(negedge clk);
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("wt_idle_busy", {15'd0, bus.scan_busy}, 16'd0);

    // Asynchronous reset at s=1: immediate IDLE, no scan_done afterwards.
    drive(1'b0, 2'd0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mr_pre_s",     {14'd0, bus.s},         16'd1);
    chk("mr_pre_valid", {15'd0, bus.sel_valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_s",     {14'd0, bus.s},         16'd0);
    chk("mr_valid", {15'd0, bus.sel_valid}, 16'd0);
    chk("mr_busy",  {15'd0, bus.scan_busy}, 16'd0);
    chk("mr_done",  {15'd0, bus.scan_done}, 16'd0);
    chk("mr_q",     q_all(),                16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mr_nodone_c%0d", c), {15'd0, bus.scan_done | bus.sel_valid}, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
